// File: rtl/sub_design_skid_if.sv
// Valid/ready handshake bundle for one skid stage: producer side (in_*) and consumer side (out_*).
// The master modport is the environment's view; the slave modport is the stage's view.
`timescale 1ns/1ps
interface sub_design_skid_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sub_design_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer (INSERT_FF=1) or a pure pass-through (INSERT_FF=0).
// in_ready is a flop, so out_ready never reaches in_ready combinationally in registered mode.
`timescale 1ns/1ps
module sub_design_skid #(
    parameter int WIDTH     = 8,
    parameter bit INSERT_FF = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    sub_design_skid_if.slave  bus,
    output logic [1:0]        occupancy,
    output logic [15:0]       beat_count
);

    // Encodings double as the occupancy value.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    logic out_fire;

    assign out_fire = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
        end else if (out_fire) begin
            beat_count <= beat_count + 16'd1;
        end
    end

    if (INSERT_FF) begin : g_reg
        state_t           state, state_next;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             ready_q;
        logic             in_fire;

        assign in_fire = bus.in_valid & ready_q;

        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        always_comb begin
            state_next = state;
            main_d     = main_q;
            skid_d     = skid_q;
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = BUSY;
                        main_d     = bus.in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (in_fire) begin
                        state_next = FULL;
                        skid_d     = bus.in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_next = BUSY;
                        main_d     = skid_q;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end

        // NOTE: payload registers are reset too, so a discarded beat can never reappear after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b0;
            end else begin
                state   <= state_next;
                main_q  <= main_d;
                skid_q  <= skid_d;
                ready_q <= (state_next != FULL);
            end
        end

        assign bus.in_ready  = ready_q;
        assign bus.out_valid = (state != EMPTY);
        assign bus.out_data  = main_q;
        assign occupancy     = state;
    end else begin : g_pass
        assign bus.in_ready  = bus.out_ready;
        assign bus.out_valid = bus.in_valid;
        assign bus.out_data  = bus.in_data;
        assign occupancy     = 2'd0;
    end

endmodule

// File: tb/tb_sub_design_skid.sv
// Directed bench for sub_design_skid: registered instance for reset, streaming, backpressure,
// simultaneous fire and counter wrap; pass-through instance for combinational tracking.
`timescale 1ns/1ps
module tb_sub_design_skid;

    logic        clk;
    logic        rst_n;
    logic [1:0]  occ_r, occ_p;
    logic [15:0] cnt_r, cnt_p;

    int n_cmp;
    int n_bad;

    sub_design_skid_if #(.WIDTH(8)) bus_r ();
    sub_design_skid_if #(.WIDTH(8)) bus_p ();

    sub_design_skid #(.WIDTH(8), .INSERT_FF(1'b1)) dut_r (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_r.slave),
        .occupancy  (occ_r),
        .beat_count (cnt_r)
    );

    sub_design_skid #(.WIDTH(8), .INSERT_FF(1'b0)) dut_p (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_p.slave),
        .occupancy  (occ_p),
        .beat_count (cnt_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        bus_r.in_valid    = 1'b0;
        bus_r.in_data     = 8'h00;
        bus_r.out_ready   = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus_r.in_valid  = 1'b0;
        bus_r.in_data   = 8'h00;
        bus_r.out_ready = 1'b0;
        bus_p.in_valid  = 1'b0;
        bus_p.in_data   = 8'h00;
        bus_p.out_ready = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, bus_r.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus_r.in_ready},  32'd0);
        check("rst_occ",       {30'd0, occ_r},           32'd0);
        check("rst_count",     {16'd0, cnt_r},           32'd0);

        // Streaming 0x01..0x10 with out_ready high.
        do_reset();
        bus_r.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus_r.in_valid = 1'b1;
            bus_r.in_data  = 8'(i);
            check("stream_in_ready", {31'd0, bus_r.in_ready}, 32'd1);
            tick();
            check("stream_valid", {31'd0, bus_r.out_valid}, 32'd1);
            check("stream_data",  {24'd0, bus_r.out_data},  32'(i));
            check("stream_occ",   {30'd0, occ_r},           32'd1);
            check("stream_count", {16'd0, cnt_r},           32'(i - 1));
        end
        bus_r.in_valid = 1'b0;
        tick();
        check("stream_final_count", {16'd0, cnt_r},           32'd16);
        check("stream_final_valid", {31'd0, bus_r.out_valid}, 32'd0);

        // Backpressure: A1 to main, A2 to skid, A3 held off.
        do_reset();
        bus_r.in_valid = 1'b1;
        bus_r.in_data  = 8'hA1;
        tick();
        check("bp_occ1",   {30'd0, occ_r},          32'd1);
        check("bp_ready1", {31'd0, bus_r.in_ready}, 32'd1);
        bus_r.in_data = 8'hA2;
        tick();
        check("bp_occ2",   {30'd0, occ_r},          32'd2);
        check("bp_ready2", {31'd0, bus_r.in_ready}, 32'd0);
        bus_r.in_data = 8'hA3;
        tick();
        tick();
        check("bp_hold_occ",  {30'd0, occ_r},          32'd2);
        check("bp_hold_data", {24'd0, bus_r.out_data}, 32'hA1);
        bus_r.out_ready = 1'b1;
        tick();
        check("bp_rel_data",  {24'd0, bus_r.out_data}, 32'hA2);
        check("bp_rel_ready", {31'd0, bus_r.in_ready}, 32'd1);
        check("bp_rel_occ",   {30'd0, occ_r},          32'd1);
        check("bp_rel_count", {16'd0, cnt_r},          32'd1);
        tick();
        check("bp_a3_data",  {24'd0, bus_r.out_data}, 32'hA3);
        check("bp_a3_count", {16'd0, cnt_r},          32'd2);
        bus_r.in_valid = 1'b0;
        tick();
        check("bp_end_count", {16'd0, cnt_r},           32'd3);
        check("bp_end_valid", {31'd0, bus_r.out_valid}, 32'd0);

        // Reset while FULL holding 0x11/0x22.
        bus_r.out_ready = 1'b0;
        bus_r.in_valid  = 1'b1;
        bus_r.in_data   = 8'h11;
        tick();
        bus_r.in_data = 8'h22;
        tick();
        check("mid_full_occ", {30'd0, occ_r}, 32'd2);
        bus_r.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus_r.out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, bus_r.in_ready},  32'd0);
        check("mid_rst_occ",   {30'd0, occ_r},           32'd0);
        check("mid_rst_count", {16'd0, cnt_r},           32'd0);
        #1;
        rst_n           = 1'b1;
        bus_r.out_ready = 1'b1;
        check("mid_rel_ready_pre", {31'd0, bus_r.in_ready}, 32'd0);
        tick();
        check("mid_rel_ready", {31'd0, bus_r.in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("mid_no_stale", {31'd0, bus_r.out_valid}, 32'd0);
            tick();
        end
        bus_r.in_valid = 1'b1;
        bus_r.in_data  = 8'h33;
        tick();
        bus_r.in_valid = 1'b0;
        check("mid_fresh_data", {24'd0, bus_r.out_data}, 32'h33);
        tick();
        check("mid_fresh_count", {16'd0, cnt_r}, 32'd1);

        // Simultaneous in_fire and out_fire in BUSY.
        do_reset();
        bus_r.in_valid = 1'b1;
        bus_r.in_data  = 8'h5A;
        tick();
        check("sim_hold_data", {24'd0, bus_r.out_data}, 32'h5A);
        bus_r.in_data   = 8'hC3;
        bus_r.out_ready = 1'b1;
        tick();
        bus_r.in_valid  = 1'b0;
        bus_r.out_ready = 1'b0;
        check("sim_data",  {24'd0, bus_r.out_data}, 32'hC3);
        check("sim_occ",   {30'd0, occ_r},          32'd1);
        check("sim_count", {16'd0, cnt_r},          32'd1);

        // Counter wrap: after tick k of a full-rate stream, k-1 beats have been output.
        do_reset();
        bus_r.out_ready = 1'b1;
        bus_r.in_valid  = 1'b1;
        for (int k = 1; k <= 65538; k++) begin
            bus_r.in_data = 8'(k);
            tick();
            if (k == 65536) check("wrap_ffff", {16'd0, cnt_r}, 32'h0000FFFF);
            if (k == 65537) check("wrap_0000", {16'd0, cnt_r}, 32'h00000000);
            if (k == 65538) check("wrap_0001", {16'd0, cnt_r}, 32'h00000001);
        end
        bus_r.in_valid = 1'b0;

        // Pass-through instance: outputs follow inputs in the same cycle.
        do_reset();
        begin
            int exp_cnt;
            exp_cnt = 0;
            for (int i = 0; i < 24; i++) begin
                bus_p.in_valid  = 1'($urandom_range(0, 1));
                bus_p.out_ready = 1'($urandom_range(0, 1));
                bus_p.in_data   = 8'($urandom_range(0, 255));
                #1;
                check("pt_valid", {31'd0, bus_p.out_valid}, {31'd0, bus_p.in_valid});
                check("pt_data",  {24'd0, bus_p.out_data},  {24'd0, bus_p.in_data});
                check("pt_ready", {31'd0, bus_p.in_ready},  {31'd0, bus_p.out_ready});
                check("pt_occ",   {30'd0, occ_p},           32'd0);
                if (bus_p.in_valid && bus_p.out_ready) exp_cnt++;
                tick();
                check("pt_count", {16'd0, cnt_p}, 32'(exp_cnt));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
